// File: rtl/rvx_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rvx_bus_arbiter
//  Description : Two-master / one-slave arbiter for the RVX instruction bus
//                (m0, read-only) and data bus (m1, read/write). It offers
//                fixed-priority or round-robin arbitration, routes the request
//                through with zero added latency, and has a response-timeout
//                watchdog that aborts stuck transfers and flags a bus error.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvx_bus_arbiter #(
  parameter int ARBITRATION    = 1,   // 0: fixed priority (m1 wins), 1: round-robin
  parameter int TIMEOUT_CYCLES = 255  // 0 disables the watchdog, legal 0..65535
) (
  input  logic        clock,
  input  logic        reset_n,
  // instruction bus (m0)
  input  logic [31:0] m0_address,
  input  logic        m0_rrequest,
  output logic [31:0] m0_rdata,
  output logic        m0_rresponse,
  // data bus (m1)
  input  logic [31:0] m1_address,
  input  logic        m1_rrequest,
  input  logic        m1_wrequest,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrobe,
  output logic [31:0] m1_rdata,
  output logic        m1_rresponse,
  output logic        m1_wresponse,
  // shared slave port
  output logic [31:0] s_address,
  output logic        s_rrequest,
  output logic        s_wrequest,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrobe,
  input  logic [31:0] s_rdata,
  input  logic        s_rresponse,
  input  logic        s_wresponse,
  // watchdog reporting
  output logic        bus_error,
  output logic        error_master
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_M0 = 2'd1,
    BUSY_M1 = 2'd2
  } state_t;

  localparam bit          WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [15:0] TO_LAST = WDOG_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_t      fsm_q;
  logic        last_grant_q;
  logic [15:0] count_q;
  logic        error_master_q;
  // Type of the transfer in flight, captured at grant so that a master
  // changing its request in the response cycle cannot alter the response
  // that is being matched.
  logic        owner_wr_q;

  logic m1_req;
  logic busy;
  logic owner;        // 1 when m1 owns the slave
  logic slave_rsp;    // slave response matching the owner's transfer type
  logic abort;
  logic done;
  logic free;
  logic grant;
  logic winner;
  logic route_valid;
  logic route_m1;

  assign m1_req    = m1_rrequest | m1_wrequest;
  assign busy      = (fsm_q != IDLE);
  assign owner     = (fsm_q == BUSY_M1);
  assign slave_rsp = busy & (owner_wr_q ? s_wresponse : s_rresponse);
  assign abort     = WDOG_EN & busy & ~slave_rsp & (count_q == TO_LAST);
  assign done      = slave_rsp | abort;
  assign free      = ~busy | done;
  assign grant     = free & (m0_rrequest | m1_req);

  // Pick the winner among the current requesters; a lone requester always wins.
  always_comb begin
    winner = m1_req;
    if (m0_rrequest & m1_req) begin
      winner = (ARBITRATION == 0) ? 1'b1 : ~last_grant_q;
    end
  end

  // The slave port follows a new grant first, else the owner of a live
  // (non-aborted) transfer, else rests at zero.
  assign route_valid = grant | (busy & ~abort);
  assign route_m1    = grant ? winner : owner;

  // Output routing; everything is held at zero while reset is asserted.
  always_comb begin
    s_address    = 32'd0;
    s_rrequest   = 1'b0;
    s_wrequest   = 1'b0;
    s_wdata      = 32'd0;
    s_wstrobe    = 4'd0;
    m0_rdata     = 32'd0;
    m0_rresponse = 1'b0;
    m1_rdata     = 32'd0;
    m1_rresponse = 1'b0;
    m1_wresponse = 1'b0;
    bus_error    = 1'b0;
    error_master = 1'b0;
    if (reset_n) begin
      if (route_valid) begin
        if (route_m1) begin
          s_address  = m1_address;
          s_rrequest = m1_rrequest & ~m1_wrequest;
          s_wrequest = m1_wrequest;
          s_wdata    = m1_wdata;
          s_wstrobe  = m1_wstrobe;
        end else begin
          s_address  = m0_address;
          s_rrequest = m0_rrequest;
        end
      end
      m0_rresponse = done & ~owner;
      m1_rresponse = done & owner & ~owner_wr_q;
      m1_wresponse = done & owner & owner_wr_q;
      // An abort never coincides with a slave response, so aborted reads return zero.
      m0_rdata     = (slave_rsp & ~owner) ? s_rdata : 32'd0;
      m1_rdata     = (slave_rsp & owner & ~owner_wr_q) ? s_rdata : 32'd0;
      bus_error    = abort;
      error_master = error_master_q;
    end
  end

  // Ownership, round-robin history and watchdog counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fsm_q          <= IDLE;
      last_grant_q   <= 1'b1;
      count_q        <= 16'd0;
      error_master_q <= 1'b0;
      owner_wr_q     <= 1'b0;
    end else begin
      if (abort) begin
        error_master_q <= owner;
      end
      if (grant) begin
        fsm_q        <= winner ? BUSY_M1 : BUSY_M0;
        last_grant_q <= winner;
        count_q      <= 16'd0;
        owner_wr_q   <= winner & m1_wrequest;
      end else if (free) begin
        fsm_q      <= IDLE;
        count_q    <= 16'd0;
        owner_wr_q <= 1'b0;
      end else if (WDOG_EN) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rvx_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvx_bus_arbiter
//  Description : Self-checking bench for rvx_bus_arbiter. Two instances share
//                the same stimulus: "rr" (round-robin, timeout 4) and "fp"
//                (fixed priority, watchdog off). A rule-level reference model
//                predicts every output of both each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rvx_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] m0_address, m1_address, m1_wdata, s_rdata;
  logic        m0_rrequest, m1_rrequest, m1_wrequest, s_rresponse, s_wresponse;
  logic [3:0]  m1_wstrobe;

  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_address, a_s_wdata;
  logic        a_m0_rresponse, a_m1_rresponse, a_m1_wresponse, a_s_rrequest, a_s_wrequest;
  logic [3:0]  a_s_wstrobe;
  logic        a_bus_error, a_error_master;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_address, b_s_wdata;
  logic        b_m0_rresponse, b_m1_rresponse, b_m1_wresponse, b_s_rrequest, b_s_wrequest;
  logic [3:0]  b_s_wstrobe;
  logic        b_bus_error, b_error_master;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  rvx_bus_arbiter #(.ARBITRATION(1), .TIMEOUT_CYCLES(4)) u_rr (
    .clock(clock), .reset_n(reset_n),
    .m0_address(m0_address), .m0_rrequest(m0_rrequest),
    .m0_rdata(a_m0_rdata), .m0_rresponse(a_m0_rresponse),
    .m1_address(m1_address), .m1_rrequest(m1_rrequest), .m1_wrequest(m1_wrequest),
    .m1_wdata(m1_wdata), .m1_wstrobe(m1_wstrobe),
    .m1_rdata(a_m1_rdata), .m1_rresponse(a_m1_rresponse), .m1_wresponse(a_m1_wresponse),
    .s_address(a_s_address), .s_rrequest(a_s_rrequest), .s_wrequest(a_s_wrequest),
    .s_wdata(a_s_wdata), .s_wstrobe(a_s_wstrobe),
    .s_rdata(s_rdata), .s_rresponse(s_rresponse), .s_wresponse(s_wresponse),
    .bus_error(a_bus_error), .error_master(a_error_master)
  );

  rvx_bus_arbiter #(.ARBITRATION(0), .TIMEOUT_CYCLES(0)) u_fp (
    .clock(clock), .reset_n(reset_n),
    .m0_address(m0_address), .m0_rrequest(m0_rrequest),
    .m0_rdata(b_m0_rdata), .m0_rresponse(b_m0_rresponse),
    .m1_address(m1_address), .m1_rrequest(m1_rrequest), .m1_wrequest(m1_wrequest),
    .m1_wdata(m1_wdata), .m1_wstrobe(m1_wstrobe),
    .m1_rdata(b_m1_rdata), .m1_rresponse(b_m1_rresponse), .m1_wresponse(b_m1_wresponse),
    .s_address(b_s_address), .s_rrequest(b_s_rrequest), .s_wrequest(b_s_wrequest),
    .s_wdata(b_s_wdata), .s_wstrobe(b_s_wstrobe),
    .s_rdata(s_rdata), .s_rresponse(s_rresponse), .s_wresponse(s_wresponse),
    .bus_error(b_bus_error), .error_master(b_error_master)
  );

  typedef struct packed {
    logic [31:0] m0_rdata;
    logic        m0_rresponse;
    logic [31:0] m1_rdata;
    logic        m1_rresponse;
    logic        m1_wresponse;
    logic [31:0] s_address;
    logic        s_rrequest;
    logic        s_wrequest;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrobe;
    logic        bus_error;
    logic        error_master;
  } exp_t;

  // Transaction-level view: who owns the slave (0 none, 1 m0, 2 m1),
  // who was granted last, how long the transfer has waited, and the
  // reported error master.
  typedef struct {
    int own;
    int last;
    int age;
    bit wr;
    bit em;
  } mst_t;

  mst_t st_a, st_b, nx_a, nx_b;
  exp_t ex_a, ex_b;

  function automatic void model_eval(input mst_t st, input int arb, input int tmo,
                                     output exp_t e, output mst_t nx);
    bit busy, rsp, abort, done, free, req0, req1, grant;
    int win, src;
    e  = '0;
    nx = st;
    if (!reset_n) begin
      nx.own = 0; nx.last = 1; nx.age = 0; nx.wr = 0; nx.em = 0;
      return;
    end
    busy  = (st.own != 0);
    rsp   = busy && (st.wr ? s_wresponse : s_rresponse);
    abort = (tmo > 0) && busy && !rsp && (st.age == tmo - 1);
    done  = rsp || abort;
    free  = !busy || done;
    req0  = m0_rrequest;
    req1  = m1_rrequest || m1_wrequest;
    grant = free && (req0 || req1);
    if (req0 && req1) win = (arb == 0) ? 1 : 1 - st.last;
    else              win = req1 ? 1 : 0;
    src = grant ? win : ((busy && !abort) ? st.own - 1 : -1);
    if (src == 0) begin
      e.s_address  = m0_address;
      e.s_rrequest = m0_rrequest;
    end else if (src == 1) begin
      e.s_address  = m1_address;
      e.s_rrequest = m1_rrequest && !m1_wrequest;
      e.s_wrequest = m1_wrequest;
      e.s_wdata    = m1_wdata;
      e.s_wstrobe  = m1_wstrobe;
    end
    if (done) begin
      if (st.own == 1)  e.m0_rresponse = 1'b1;
      else if (st.wr)   e.m1_wresponse = 1'b1;
      else              e.m1_rresponse = 1'b1;
    end
    if (rsp && st.own == 1)           e.m0_rdata = s_rdata;
    if (rsp && st.own == 2 && !st.wr) e.m1_rdata = s_rdata;
    e.bus_error    = abort;
    e.error_master = st.em;
    if (abort) nx.em = (st.own == 2);
    if (grant) begin
      nx.own = win + 1; nx.last = win; nx.age = 0; nx.wr = (win == 1) && m1_wrequest;
    end else if (free) begin
      nx.own = 0; nx.age = 0; nx.wr = 0;
    end else begin
      nx.age = (tmo > 0) ? st.age + 1 : 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all(input string who, input exp_t o, input exp_t e);
    chk({who, ".m0_rdata"},     o.m0_rdata,     e.m0_rdata);
    chk({who, ".m0_rresponse"}, o.m0_rresponse, e.m0_rresponse);
    chk({who, ".m1_rdata"},     o.m1_rdata,     e.m1_rdata);
    chk({who, ".m1_rresponse"}, o.m1_rresponse, e.m1_rresponse);
    chk({who, ".m1_wresponse"}, o.m1_wresponse, e.m1_wresponse);
    chk({who, ".s_address"},    o.s_address,    e.s_address);
    chk({who, ".s_rrequest"},   o.s_rrequest,   e.s_rrequest);
    chk({who, ".s_wrequest"},   o.s_wrequest,   e.s_wrequest);
    chk({who, ".s_wdata"},      o.s_wdata,      e.s_wdata);
    chk({who, ".s_wstrobe"},    o.s_wstrobe,    e.s_wstrobe);
    chk({who, ".bus_error"},    o.bus_error,    e.bus_error);
    chk({who, ".error_master"}, o.error_master, e.error_master);
  endtask

  // Let inputs settle, then compare both instances against the model.
  task automatic settle();
    exp_t oa, ob;
    #3;
    model_eval(st_a, 1, 4, ex_a, nx_a);
    model_eval(st_b, 0, 0, ex_b, nx_b);
    oa = {a_m0_rdata, a_m0_rresponse, a_m1_rdata, a_m1_rresponse, a_m1_wresponse,
          a_s_address, a_s_rrequest, a_s_wrequest, a_s_wdata, a_s_wstrobe,
          a_bus_error, a_error_master};
    ob = {b_m0_rdata, b_m0_rresponse, b_m1_rdata, b_m1_rresponse, b_m1_wresponse,
          b_s_address, b_s_rrequest, b_s_wrequest, b_s_wdata, b_s_wstrobe,
          b_bus_error, b_error_master};
    check_all("rr", oa, ex_a);
    check_all("fp", ob, ex_b);
  endtask

  task automatic adv();
    @(posedge clock);
    st_a = nx_a;
    st_b = nx_b;
    #1;
  endtask

  task automatic clr_in();
    m0_address = 0; m0_rrequest = 0;
    m1_address = 0; m1_rrequest = 0; m1_wrequest = 0; m1_wdata = 0; m1_wstrobe = 0;
    s_rdata = 0; s_rresponse = 0; s_wresponse = 0;
  endtask

  // Respond to whatever is still in flight and return both instances to idle.
  task automatic drain();
    clr_in();
    s_rresponse = 1; s_wresponse = 1;
    for (int i = 0; i < 3; i++) begin settle(); adv(); end
    clr_in();
    settle(); adv();
  endtask

  task automatic reset_pulse();
    clr_in();
    reset_n = 0;
    settle(); adv();
    reset_n = 1;
  endtask

  initial begin
    bit   p0, p1;
    int   k;
    exp_t look;
    mst_t dummy;
    st_a = '{own: 0, last: 1, age: 0, wr: 0, em: 0};
    st_b = st_a;
    clr_in();
    reset_n = 0;
    settle();   // outputs while in reset
    adv();
    reset_n = 1;

    // m0 alone reads 0x100, slave answers two cycles later
    m0_rrequest = 1; m0_address = 32'h100;
    settle();
    chk("t1 s_address", a_s_address, 32'h100);
    chk("t1 s_rrequest", a_s_rrequest, 1);
    adv();
    settle(); adv();
    s_rresponse = 1; s_rdata = 32'hDEADBEEF; m0_rrequest = 0;
    settle();
    chk("t1 m0_rresponse", a_m0_rresponse, 1);
    chk("t1 m0_rdata", a_m0_rdata, 32'hDEADBEEF);
    chk("t1 m1_rresponse", a_m1_rresponse, 0);
    adv();
    clr_in();

    // fixed priority: simultaneous m0 read and m1 write, write goes first
    m0_rrequest = 1; m0_address = 32'h200;
    m1_wrequest = 1; m1_address = 32'h300; m1_wdata = 32'hA5A5A5A5; m1_wstrobe = 4'b0011;
    settle();
    chk("t2 s_wrequest", b_s_wrequest, 1);
    chk("t2 s_address w", b_s_address, 32'h300);
    chk("t2 s_wstrobe", b_s_wstrobe, 4'b0011);
    adv();
    s_wresponse = 1; m1_wrequest = 0;
    settle();
    chk("t2 m1_wresponse", b_m1_wresponse, 1);
    chk("t2 s_address r", b_s_address, 32'h200);
    chk("t2 s_rrequest", b_s_rrequest, 1);
    adv();
    s_wresponse = 0; s_rresponse = 1; s_rdata = 32'h12345678; m0_rrequest = 0;
    settle();
    chk("t2 m0_rresponse", b_m0_rresponse, 1);
    chk("t2 m0_rdata", b_m0_rdata, 32'h12345678);
    adv();

    // round-robin alternation after reset, both masters always requesting
    reset_pulse();
    m0_rrequest = 1; m0_address = 32'h10;
    m1_wrequest = 1; m1_address = 32'h20; m1_wdata = 32'h55; m1_wstrobe = 4'hF;
    settle();
    chk("t3 grant0 m1", a_s_wrequest, 0);
    chk("t3 grant0 addr", a_s_address, 32'h10);
    adv();
    for (int i = 1; i < 6; i++) begin
      s_rresponse = 1; s_wresponse = 1;
      settle();
      chk($sformatf("t3 grant%0d m1", i), a_s_wrequest, 32'(i % 2));
      chk($sformatf("t3 grant%0d addr", i), a_s_address, (i % 2 == 1) ? 32'h20 : 32'h10);
      adv();
    end
    m0_rrequest = 0; m1_wrequest = 0;
    settle(); adv();
    drain();

    // watchdog abort of an m1 read, nobody else waiting
    m1_rrequest = 1; m1_address = 32'h400;
    settle(); adv();
    for (int i = 1; i < 4; i++) begin
      settle();
      chk("t4 no early error", a_bus_error, 0);
      adv();
    end
    m1_rrequest = 0;
    settle();
    chk("t4 m1_rresponse", a_m1_rresponse, 1);
    chk("t4 m1_rdata", a_m1_rdata, 0);
    chk("t4 bus_error", a_bus_error, 1);
    chk("t4 s_rrequest", a_s_rrequest, 0);
    adv();
    settle();
    chk("t4 error_master", a_error_master, 1);
    chk("t4 single pulse", a_bus_error, 0);
    adv();
    drain();

    // watchdog abort with m0 pending: m0 takes over in the abort cycle
    m1_rrequest = 1; m1_address = 32'h404;
    settle(); adv();
    m0_rrequest = 1; m0_address = 32'h500;
    for (int i = 1; i < 4; i++) begin settle(); adv(); end
    m1_rrequest = 0;
    settle();
    chk("t4b bus_error", a_bus_error, 1);
    chk("t4b s_address", a_s_address, 32'h500);
    chk("t4b s_rrequest", a_s_rrequest, 1);
    adv();
    s_rresponse = 1; s_rdata = 32'hCAFEF00D; m0_rrequest = 0;
    settle();
    chk("t4b m0_rresponse", a_m0_rresponse, 1);
    chk("t4b m0_rdata", a_m0_rdata, 32'hCAFEF00D);
    adv();
    drain();

    // m1 read+write together is a write only
    m1_rrequest = 1; m1_wrequest = 1; m1_address = 32'h600; m1_wdata = 32'h11223344; m1_wstrobe = 4'hF;
    settle();
    chk("t5 s_wrequest", a_s_wrequest, 1);
    chk("t5 s_rrequest", a_s_rrequest, 0);
    adv();
    m1_rrequest = 0; m1_wrequest = 0; s_rresponse = 1; s_wresponse = 1;
    settle();
    chk("t5 m1_wresponse", a_m1_wresponse, 1);
    chk("t5 m1_rresponse", a_m1_rresponse, 0);
    adv();
    clr_in();

    // reset in the middle of an m1 transfer
    m1_rrequest = 1; m1_address = 32'h700;
    settle(); adv();
    reset_n = 0;
    settle();
    chk("t6 s_rrequest in reset", a_s_rrequest, 0);
    chk("t6 s_address in reset", a_s_address, 0);
    adv();
    reset_n = 1; m1_rrequest = 0; s_rresponse = 1; s_rdata = 32'h77;
    settle();
    chk("t6 stale response", a_m1_rresponse, 0);
    adv();
    s_rresponse = 0;
    m0_rrequest = 1; m0_address = 32'h800; m1_rrequest = 1; m1_address = 32'h900;
    settle();
    chk("t6 tie to m0", a_s_address, 32'h800);
    adv();
    drain();

    // random traffic; masters follow the protocol as seen on the rr instance
    p0 = 0; p1 = 0;
    for (int c = 0; c < 3000; c++) begin
      reset_n     = ($urandom_range(0, 60) != 0);
      s_rresponse = ($urandom_range(0, 2) == 0);
      s_wresponse = ($urandom_range(0, 2) == 0);
      s_rdata     = $urandom;
      model_eval(st_a, 1, 4, look, dummy);
      if (!p0 || look.m0_rresponse) begin
        p0 = $urandom_range(0, 1);
        m0_rrequest = p0;
        m0_address  = $urandom;
      end
      if (!p1 || look.m1_rresponse || look.m1_wresponse) begin
        p1 = $urandom_range(0, 1);
        k  = $urandom_range(0, 3);
        m1_rrequest = p1 && (k != 2);
        m1_wrequest = p1 && (k >= 2);
        m1_address  = $urandom;
        m1_wdata    = $urandom;
        m1_wstrobe  = 4'($urandom);
      end
      settle();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rvx_bus_arbiter.md
Name: rvx_bus_arbiter

Overview:
- Two-master, one-slave arbiter that lets the RVX core's instruction bus (m0, read-only) and data bus (m1, read/write) share a single memory port (s).
- Uses the core's request/response protocol unchanged:
  - A master holds its request, address, wdata and wstrobe stable until it sees its response.
  - It may issue a new request in the same cycle the response arrives.
- Adds selectable fixed-priority or round-robin arbitration, plus a response-timeout watchdog that reports bus errors.

Parameters:
- ARBITRATION, 1: 0 = fixed priority (m1 always wins ties); 1 = round-robin (the master not granted last wins ties).
- TIMEOUT_CYCLES, 255: cycles in BUSY without a slave response before the arbiter aborts the transfer. 0 disables the watchdog. Legal range 0..65535.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- m0_address  in  32  instruction bus address
- m0_rrequest  in  1  instruction read request
- m0_rdata  out  32  instruction read data
- m0_rresponse  out  1  instruction read done
- m1_address  in  32  data bus address
- m1_rrequest  in  1  data read request
- m1_wrequest  in  1  data write request
- m1_wdata  in  32  write data
- m1_wstrobe  in  4  byte strobes
- m1_rdata  out  32  data read data
- m1_rresponse  out  1  data read done
- m1_wresponse  out  1  data write done
- s_address  out  32  slave address
- s_rrequest  out  1  slave read request
- s_wrequest  out  1  slave write request
- s_wdata  out  32  slave write data
- s_wstrobe  out  4  slave strobes
- s_rdata  in  32  slave read data
- s_rresponse  in  1  slave read done
- s_wresponse  in  1  slave write done
- bus_error  out  1  one-cycle pulse on timeout abort
- error_master  out  1  master whose transfer was aborted (0 = m0, 1 = m1); updated only on a bus_error pulse

Behaviour:

State and registers:
- FSM states: IDLE, BUSY_M0, BUSY_M1.
- Registered state: fsm, last_grant (1 bit), timeout counter (16 bit), error_master.

Arbitration:
- free = (fsm == IDLE) | (slave response or timeout in the current cycle).
- m1 request = m1_rrequest | m1_wrequest.
- If m1 asserts both rrequest and wrequest, the transfer is a write only: s_rrequest = 0, and only m1_wresponse is returned.
- When free and at least one master requests, the winner is chosen combinationally in that cycle:
  - Fixed priority: m1 wins.
  - Round-robin: on a tie, the master with index != last_grant wins.
  - A single requester always wins.
- On a grant: fsm <= BUSY_winner, last_grant <= winner, counter <= 0.
- When free and no master requests: fsm <= IDLE.

Slave port routing:
- s_* outputs are driven combinationally from the granted master's live inputs in the grant cycle.
- They are driven from the owner's inputs in every BUSY cycle up to and including the response cycle, so there is zero added request latency.
- In IDLE with no request, and during reset, all s_* outputs are 0.
- When the winner is m0: s_wrequest = 0 and s_wdata/s_wstrobe = 0.
- The loser sees no response and is expected to stall and hold its request. It is granted at the next free cycle.

Response routing:
- The earliest response is one cycle after the grant.
- In BUSY_Mx, s_rresponse / s_wresponse are routed only to master x.
- The other master's response outputs stay 0.
- A slave response while IDLE is ignored. A response whose type does not match the owner's request is ignored.
- m0_rdata = s_rdata when m0_rresponse is asserted, else 0. m1_rdata follows the same rule.

Back-to-back transfers:
- In a response cycle the arbitration runs again in the same cycle.
- The next transfer's s_* values replace the current ones in that same cycle.
- There are no bubble cycles between transfers.

Watchdog (TIMEOUT_CYCLES > 0):
- The counter increments each BUSY cycle without a response.
- When counter == TIMEOUT_CYCLES - 1 and no response arrives, that cycle is an abort cycle:
  - The arbiter asserts the owner's matching response itself, with rdata = 32'h00000000.
  - bus_error = 1 for one cycle.
  - error_master <= owner.
  - The aborted transfer's s_* request signals are forced to 0 that cycle.
  - Re-arbitration proceeds as for a normal response cycle.
- When TIMEOUT_CYCLES = 0, the counter is held at 0 and bus_error never pulses.

Reset:
- When reset_n = 0 at a clock edge: fsm = IDLE, last_grant = 1 (so m0 wins the first round-robin tie), counter = 0, error_master = 0.
- During reset all outputs are held 0 combinationally.
- A reset mid-transfer drops the transfer. No response is generated, and a later slave response while IDLE is ignored.

Test Plan:
- m0 alone reads 0x00000100; slave responds 2 cycles later with 0xDEADBEEF → s_address = 0x100 in the request cycle; m0_rresponse = 1 with m0_rdata = 0xDEADBEEF exactly in the slave response cycle; m1 outputs stay 0.
- ARBITRATION = 0, m0 reads 0x200 and m1 writes 0xA5A5A5A5 (strobe 4'b0011) to 0x300 in the same cycle; slave responds after 1 cycle → the write goes first, m1_wresponse = 1, and in that same cycle s_address = 0x200 with s_rrequest = 1; the m0 response comes one cycle later.
- ARBITRATION = 1, both masters request continuously for 6 transfers with single-cycle slave responses → grants alternate m0, m1, m0, m1, m0, m1, starting with m0 after reset, with no idle cycles.
- TIMEOUT_CYCLES = 4, m1 reads 0x400 and the slave never responds → on the 4th BUSY cycle: m1_rresponse = 1, m1_rdata = 0, bus_error pulses once, error_master = 1, s_rrequest = 0; a pending m0 request is granted in the same cycle.
- m1 asserts rrequest and wrequest together → s_wrequest = 1, s_rrequest = 0; on the slave write response only m1_wresponse pulses.
- reset_n = 0 for 1 cycle while BUSY_M1; slave responds the next cycle → no m1 response; fsm = IDLE; all s_* = 0 during reset; next round-robin tie is granted to m0.
